// File: rtl/video_timing.sv
// Raster timing generator: h/v counters, sync/blank flags, scan address
// and IRQ sources, advanced once per en_e strobe.
module video_timing #(
    parameter int H_TOTAL       = 64,
    parameter int H_ACTIVE      = 50,
    parameter int HSYNC_START   = 54,
    parameter int HSYNC_WIDTH   = 4,
    parameter int V_TOTAL       = 260,
    parameter int V_ACTIVE      = 248,
    parameter int VSYNC_START   = 250,
    parameter int VSYNC_WIDTH   = 3,
    parameter int COUNT240_LINE = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_e,
    output logic [5:0]  h_count,
    output logic [8:0]  v_count,
    output logic [13:0] video_addr,
    output logic [7:0]  vcount_reg,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync,
    output logic        va11,
    output logic        count240,
    output logic        pixel_load,
    output logic        line_start,
    output logic        frame_start
);

    localparam logic [5:0] H_LAST  = 6'(H_TOTAL - 1);
    localparam logic [5:0] H_ACT   = 6'(H_ACTIVE);
    localparam logic [5:0] HS_BEG  = 6'(HSYNC_START);
    localparam logic [5:0] HS_END  = 6'(HSYNC_START + HSYNC_WIDTH);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);
    localparam logic [8:0] VS_BEG  = 9'(VSYNC_START);
    localparam logic [8:0] VS_END  = 9'(VSYNC_START + VSYNC_WIDTH);
    localparam logic [8:0] V_240   = 9'(COUNT240_LINE);

    logic       h_wrap;
    logic       v_wrap;
    logic [5:0] h_next;
    logic [8:0] v_next;
    logic       hblank_next;
    logic       vblank_next;
    logic       hsync_next;
    logic       vsync_next;

    // Flags are derived from the position the counters are about to take,
    // so every registered output agrees with the counters in the same clk.
    always_comb begin
        h_wrap      = (h_count == H_LAST);
        v_wrap      = (v_count == V_LAST);
        h_next      = h_wrap ? 6'd0 : h_count + 6'd1;
        v_next      = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? 9'd0 : v_count + 9'd1;
        end
        hblank_next = (h_next >= H_ACT);
        vblank_next = (v_next >= V_ACT);
        hsync_next  = (h_next >= HS_BEG) && (h_next < HS_END);
        vsync_next  = (v_next >= VS_BEG) && (v_next < VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count     <= '0;
            v_count     <= '0;
            video_addr  <= '0;
            vcount_reg  <= '0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            va11        <= 1'b0;
            count240    <= 1'b0;
            pixel_load  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_load  <= en_e && !hblank_next && !vblank_next;
            line_start  <= en_e && h_wrap;
            frame_start <= en_e && h_wrap && v_wrap;
            if (en_e) begin
                h_count    <= h_next;
                v_count    <= v_next;
                video_addr <= {h_next, v_next[7:0]};
                vcount_reg <= {v_next[7:2], 2'b00};
                hblank     <= hblank_next;
                vblank     <= vblank_next;
                hsync      <= hsync_next;
                vsync      <= vsync_next;
                va11       <= v_next[5];
                count240   <= (v_next >= V_240);
            end
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: reset, line/frame wraps, sync and IRQ
// windows, frame length and mid-frame reset.
module tb_video_timing;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_e = 1'b0;
    logic [5:0]  h_count;
    logic [8:0]  v_count;
    logic [13:0] video_addr;
    logic [7:0]  vcount_reg;
    logic        hblank;
    logic        vblank;
    logic        hsync;
    logic        vsync;
    logic        va11;
    logic        count240;
    logic        pixel_load;
    logic        line_start;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    video_timing dut (
        .clk        (clk),
        .rst        (rst),
        .en_e       (en_e),
        .h_count    (h_count),
        .v_count    (v_count),
        .video_addr (video_addr),
        .vcount_reg (vcount_reg),
        .hblank     (hblank),
        .vblank     (vblank),
        .hsync      (hsync),
        .vsync      (vsync),
        .va11       (va11),
        .count240   (count240),
        .pixel_load (pixel_load),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n back-to-back strobes; returns at a negedge with en_e low
    task automatic adv(input int n);
        @(negedge clk);
        en_e = 1'b1;
        repeat (n) @(negedge clk);
        en_e = 1'b0;
    endtask

    function automatic logic [8:0] flags();
        return {hblank, vblank, hsync, vsync, va11, count240,
                pixel_load, line_start, frame_start};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  seen;
        bit  addr_seen;
        logic [8:0] vv;

        // reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_h", h_count, 0);
        check("rst_v", v_count, 0);
        check("rst_flags", flags(), 0);
        check("rst_addr", video_addr, 0);
        check("rst_vreg", vcount_reg, 0);

        // first strobe
        adv(1);
        check("e1_h", h_count, 1);
        check("e1_v", v_count, 0);
        check("e1_pl", pixel_load, 1);
        check("e1_fs", frame_start, 0);
        @(negedge clk);
        check("e1_pl_off", pixel_load, 0);
        check("e1_hold", h_count, 1);

        adv(48);
        check("h49_h", h_count, 49);
        check("h49_pl", pixel_load, 1);
        adv(1);
        check("h50_h", h_count, 50);
        check("h50_hb", hblank, 1);
        check("h50_pl", pixel_load, 0);

        // hsync window and rest of hblank
        for (int h = 51; h <= 63; h++) begin
            adv(1);
            check("hs_h", h_count, h);
            check("hs_sync", hsync, (h >= 54 && h <= 57));
            check("hs_hb", hblank, 1);
            check("hs_pl", pixel_load, 0);
        end

        // line wrap
        adv(1);
        check("lw_h", h_count, 0);
        check("lw_v", v_count, 1);
        check("lw_ls", line_start, 1);
        check("lw_fs", frame_start, 0);
        check("lw_hb", hblank, 0);
        check("lw_pl", pixel_load, 1);
        @(negedge clk);
        check("lw_ls_off", line_start, 0);

        // vertical windows, one line at a time
        for (int v = 2; v <= 259; v++) begin
            vv = 9'(v);
            adv(64);
            check("vl_h", h_count, 0);
            check("vl_v", v_count, v);
            check("vl_vs", vsync, (v >= 250 && v <= 252));
            check("vl_vb", vblank, (v >= 248));
            check("vl_va11", va11, vv[5]);
            check("vl_c240", count240, (v >= 240));
            check("vl_vreg", vcount_reg, {vv[7:2], 2'b00});
            check("vl_ls", line_start, 1);
            check("vl_pl", pixel_load, (v < 248));
        end

        adv(63);
        check("fe_h", h_count, 63);
        check("fe_v", v_count, 259);
        check("fe_addr", video_addr, 14'h3F03);

        // frame wrap
        adv(1);
        check("fw_h", h_count, 0);
        check("fw_v", v_count, 0);
        check("fw_ls", line_start, 1);
        check("fw_fs", frame_start, 1);
        check("fw_vb", vblank, 0);
        check("fw_c240", count240, 0);
        check("fw_pl", pixel_load, 1);
        @(negedge clk);
        check("fw_fs_off", frame_start, 0);
        check("fw_ls_off", line_start, 0);

        // whole frame with gaps between strobes
        n = 0;
        seen = 1'b0;
        addr_seen = 1'b0;
        while (!seen && n < 20000) begin
            @(negedge clk);
            en_e = 1'b1;
            @(negedge clk);
            en_e = 1'b0;
            n++;
            if (h_count == 6'd63 && v_count == 9'd5) begin
                addr_seen = 1'b1;
                check("ff_addr", video_addr, 14'h3F05);
            end
            if (frame_start) seen = 1'b1;
        end
        check("ff_seen", seen, 1);
        check("ff_len", n, 16640);
        check("ff_addr_seen", addr_seen, 1);
        @(negedge clk);
        check("ff_fs_off", frame_start, 0);

        // reset mid-line with en_e also high
        adv(100 * 64 + 20);
        check("mr_pre_h", h_count, 20);
        check("mr_pre_v", v_count, 100);
        @(negedge clk);
        rst = 1'b1;
        en_e = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en_e = 1'b0;
        check("mr_h", h_count, 0);
        check("mr_v", v_count, 0);
        check("mr_flags", flags(), 0);
        check("mr_addr", video_addr, 0);
        check("mr_vreg", vcount_reg, 0);
        @(negedge clk);
        check("mr_idle_fs", frame_start, 0);
        adv(1);
        check("mr_e1_h", h_count, 1);
        check("mr_e1_v", v_count, 0);
        check("mr_e1_pl", pixel_load, 1);
        check("mr_e1_fs", frame_start, 0);

        // hold between strobes
        repeat (10) @(negedge clk);
        check("hold_h", h_count, 1);
        check("hold_pl", pixel_load, 0);
        adv(1);
        check("hold_next_h", h_count, 2);
        check("hold_next_addr", video_addr, 14'h0200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
